// File: rtl/axis_frame_length_check.sv
// AXI-Stream frame length policer: tags runt frames via tuser and truncates
// oversize frames at MAX_LEN, discarding the remainder, ahead of the frame FIFO.
module axis_frame_length_check #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MIN_LEN    = 4,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  frame_too_short,
  output logic                  frame_too_long,
  output logic [LEN_WIDTH-1:0]  frame_len
);

  typedef enum logic [0:0] {
    PASS = 1'b0,
    DROP = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] cnt_next;
  logic                 accept;
  logic                 load;
  logic                 is_runt;
  logic                 hit_max;

  assign accept   = input_axis_tvalid & input_axis_tready;
  assign cnt_next = cnt_q + LEN_WIDTH'(1);
  assign is_runt  = cnt_next < LEN_WIDTH'(MIN_LEN);
  assign hit_max  = cnt_next == LEN_WIDTH'(MAX_LEN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter DROP on truncation, leave on the discarded frame's tlast
  always_comb begin
    state_d = state_q;
    case (state_q)
      PASS:    if (load && !input_axis_tlast && hit_max) state_d = DROP;
      DROP:    if (accept && input_axis_tlast) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  // Handshake: DROP swallows the tail regardless of downstream backpressure
  always_comb begin
    input_axis_tready = output_axis_tready | ~output_axis_tvalid;
    load              = 1'b0;
    case (state_q)
      PASS:    load = input_axis_tvalid & input_axis_tready;
      DROP:    input_axis_tready = 1'b1;
      default: load = 1'b0;
    endcase
  end

  // Output register, beat counter and per-frame status
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q              <= '0;
      output_axis_tdata  <= '0;
      output_axis_tvalid <= 1'b0;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 1'b0;
      frame_too_short    <= 1'b0;
      frame_too_long     <= 1'b0;
      frame_len          <= '0;
    end else begin
      frame_too_short <= 1'b0;
      frame_too_long  <= 1'b0;
      if (load) begin
        output_axis_tdata  <= input_axis_tdata;
        output_axis_tvalid <= 1'b1;
        if (input_axis_tlast) begin
          output_axis_tlast <= 1'b1;
          output_axis_tuser <= input_axis_tuser | is_runt;
          cnt_q             <= '0;
          frame_len         <= cnt_next;
          frame_too_short   <= is_runt;
        end else if (hit_max) begin
          output_axis_tlast <= 1'b1;
          output_axis_tuser <= 1'b1;
          cnt_q             <= '0;
          frame_len         <= LEN_WIDTH'(MAX_LEN);
          frame_too_long    <= 1'b1;
        end else begin
          output_axis_tlast <= 1'b0;
          output_axis_tuser <= 1'b0;
          cnt_q             <= cnt_next;
        end
      end else if (output_axis_tready) begin
        output_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_length_check.sv
// Bench for axis_frame_length_check: frame-level reference model, per-cycle
// output compare and directed scenarios with literal expectations.
module tb_axis_frame_length_check;

  localparam int unsigned DW      = 8;
  localparam int unsigned LW      = 16;
  localparam int unsigned MIN_LEN = 4;
  localparam int unsigned MAX_LEN = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_tdata = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic          in_tlast = 1'b0;
  logic          in_tuser = 1'b0;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic          out_tlast;
  logic          out_tuser;
  logic          too_short;
  logic          too_long;
  logic [LW-1:0] frame_len;

  axis_frame_length_check #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .input_axis_tdata(in_tdata), .input_axis_tvalid(in_tvalid),
    .input_axis_tready(in_tready), .input_axis_tlast(in_tlast),
    .input_axis_tuser(in_tuser),
    .output_axis_tdata(out_tdata), .output_axis_tvalid(out_tvalid),
    .output_axis_tready(out_tready), .output_axis_tlast(out_tlast),
    .output_axis_tuser(out_tuser),
    .frame_too_short(too_short), .frame_too_long(too_long),
    .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  typedef struct {
    int unsigned len;
    logic        s;
    logic        g;
  } event_t;

  beat_t  exp_q[$];
  event_t ev_q[$];
  beat_t  cur;
  event_t ev;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_short_seen = 0;
  int   n_long_seen = 0;
  bit   checking = 1'b0;
  bit   throttle = 1'b0;
  bit   lat_check = 1'b0;
  logic held_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a whole input frame must turn into on the output
  task automatic model_frame(input int n, input logic [DW-1:0] base, input logic u);
    int    fwd;
    beat_t b;
    event_t e;
    fwd = (n > int'(MAX_LEN)) ? int'(MAX_LEN) : n;
    for (int i = 0; i < fwd; i++) begin
      b.d = base + DW'(i);
      b.l = (i == fwd - 1);
      b.u = 1'b0;
      if (b.l) b.u = (n > int'(MAX_LEN)) ? 1'b1 : (u | (n < int'(MIN_LEN)));
      exp_q.push_back(b);
    end
    e.len = fwd;
    e.s   = (n <= int'(MAX_LEN)) && (n < int'(MIN_LEN));
    e.g   = n > int'(MAX_LEN);
    ev_q.push_back(e);
  endtask

  // Drive one beat; returns at posedge+1 after it was accepted
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic u);
    logic acc;
    int   n;
    in_tdata  = d;
    in_tlast  = last;
    in_tuser  = u;
    in_tvalid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no tready expected tready within 1000 cycles");
    end
    in_tvalid = 1'b0;
    if (lat_check) chk("latency", {23'd0, out_tvalid, out_tdata}, {23'd0, 1'b1, d});
  endtask

  task automatic send_frame(input int n, input logic [DW-1:0] base, input logic u);
    model_frame(n, base, u);
    for (int i = 0; i < n; i++) send_beat(base + DW'(i), i == n - 1, u);
  endtask

  task automatic drain();
    repeat (20) @(posedge clk);
    #1;
  endtask

  // Downstream ready: random when throttling, otherwise always ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle compare of the output stage against the model
  always @(negedge clk) begin
    if (checking) begin
      if (out_tvalid && !held_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {23'd0, out_tvalid, out_tdata}, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("beat", {22'd0, out_tlast, out_tuser, out_tdata}, {22'd0, cur.l, cur.u, cur.d});
          if (cur.l) begin
            if (ev_q.size() == 0) begin
              chk("unexpected_last", 32'd1, 32'd0);
            end else begin
              ev = ev_q.pop_front();
              chk("pulses", {30'd0, too_short, too_long}, {30'd0, ev.s, ev.g});
              chk("frame_len", 32'(frame_len), ev.len);
            end
          end else begin
            chk("pulses_mid", {30'd0, too_short, too_long}, 32'd0);
          end
        end
      end else if (out_tvalid) begin
        chk("hold_stable", {22'd0, out_tlast, out_tuser, out_tdata}, {22'd0, cur.l, cur.u, cur.d});
        chk("pulses_hold", {30'd0, too_short, too_long}, 32'd0);
      end else begin
        chk("pulses_idle", {30'd0, too_short, too_long}, 32'd0);
      end
      n_short_seen += int'(too_short);
      n_long_seen  += int'(too_long);
    end
    held_prev = out_tvalid & ~out_tready & ~rst;
  end

  initial begin
    int lens[10];
    int users[10];
    lens  = '{1, 3, 4, 7, 16, 17, 20, 2, 5, 10};
    users = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {13'd0, out_tvalid, out_tlast, out_tuser, frame_len}, 32'd0);
    chk("reset_pulses", {30'd0, too_short, too_long}, 32'd0);
    rst = 1'b0;
    checking = 1'b1;

    // Clean 6-beat frame with latency check
    lat_check = 1'b1;
    send_frame(6, 8'h01, 1'b0);
    lat_check = 1'b0;
    drain();
    chk("t1_len", 32'(frame_len), 32'd6);
    chk("t1_pulses", n_short_seen + n_long_seen, 32'd0);

    // Runt frame
    send_frame(2, 8'h10, 1'b0);
    drain();
    chk("t2_len", 32'(frame_len), 32'd2);
    chk("t2_short", n_short_seen, 32'd1);

    // Oversize frame, then a clean follower
    send_frame(20, 8'h20, 1'b0);
    drain();
    chk("t3_len", 32'(frame_len), 32'd16);
    chk("t3_long", n_long_seen, 32'd1);
    send_frame(5, 8'h40, 1'b0);
    drain();
    chk("t3_follow_len", 32'(frame_len), 32'd5);

    // Exactly MAX_LEN is legal
    send_frame(16, 8'h50, 1'b0);
    drain();
    chk("t4_len", 32'(frame_len), 32'd16);
    chk("t4_long", n_long_seen, 32'd1);

    // Mixed frames under random backpressure
    throttle = 1'b1;
    for (int f = 0; f < 10; f++) send_frame(lens[f], DW'(8'h60 + 8'(f * 16)), users[f][0]);
    throttle = 1'b0;
    drain();
    chk("t5_len", 32'(frame_len), 32'd10);
    chk("t5_short", n_short_seen, 32'd4);
    chk("t5_long", n_long_seen, 32'd3);

    // Reset after beat 3, then a fresh 5-beat frame
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{d: DW'(8'hA0 + 8'(i)), l: 1'b0, u: 1'b0});
      send_beat(DW'(8'hA0 + 8'(i)), 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_tvalid_after_rst", {31'd0, out_tvalid}, 32'd0);
    chk("t6_len_after_rst", 32'(frame_len), 32'd0);
    rst = 1'b0;
    send_frame(5, 8'hB0, 1'b0);
    drain();
    chk("t6_len", 32'(frame_len), 32'd5);

    chk("exp_queue_empty", exp_q.size(), 32'd0);
    chk("event_queue_empty", ev_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
